sha_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single testbench memory port (mem_clk/mem_we/mem_addr/mem_write_data/mem_read_data) between NUM_REQ hash requesters, such as several bitcoin_hash-style cores reading message words and writing hash outputs.
- A grant is held for the whole burst, for as long as the owner keeps req asserted.
- Read data is returned to the requester that issued the read, using the memory's fixed 1-cycle read latency.
- Sits between the hash cores and the memory model; the arbiter drives mem_clk.

---
 rtl/sha_pkg.sv | 13 +
 rtl/sha_mem_arbiter_rr_pick.sv | 31 +++
 rtl/sha_mem_arbiter.sv | 118 +++++++++++
 tb/tb_sha_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and memory-interface constants for the hash-core memory arbiter.
package sha_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/sha_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set, non-excluded request bit,
// searching upward from ptr and wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N-1:0]     excl,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   int k;

   // Scan N positions starting at ptr; the first eligible hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      k     = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         if (!found && req[k] && !excl[k]) begin
            found = 1'b1;
            idx   = k[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ hash cores.
// Grant is held for as long as the owner keeps req high; read data returns
// to the issuing requester one cycle after the address is presented.
module sha_mem_arbiter
   import sha_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   output logic [NUM_REQ-1:0]        grant,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0]         rdata,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic                      mem_clk,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_write_data,
   input  logic [DATA_W-1:0]         mem_read_data
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_t         state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   nxt_ptr;
   logic [IDX_W-1:0]   pick_ptr;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic [NUM_REQ-1:0] excl;

   assign mem_clk = clk;
   assign rdata   = mem_read_data;
   assign nxt_ptr = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

   // On release the search starts just past the owner and skips it, so a
   // releasing owner can never re-win at its own release edge.
   always_comb begin
      pick_ptr = rr_ptr;
      excl     = '0;
      if (state == BUSY) begin
         pick_ptr = nxt_ptr;
         excl     = grant;
      end
   end

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .excl  (excl),
      .idx   (win_idx),
      .found (win_found)
   );

   // Arbitration FSM: grab on any request, hold while owner requests, hand off with no idle gap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         grant  <= '0;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state <= BUSY;
                  grant <= ONE << win_idx;
                  owner <= win_idx;
               end
            end
            BUSY: begin
               if (!req[owner]) begin
                  rr_ptr <= nxt_ptr;
                  if (win_found) begin
                     grant <= ONE << win_idx;
                     owner <= win_idx;
                  end else begin
                     grant <= '0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read tag: the one-hot rvalid register remembers who issued the read, so
   // a read in the owner's final cycle still returns to it after handoff.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rvalid <= '0;
      else          rvalid <= (state == BUSY && !req_we[owner]) ? (ONE << owner) : '0;
   end

   // Memory mux: only the granted requester reaches the port; idle drives zeros.
   always_comb begin
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      if (|grant) begin
         mem_we         = req_we[owner];
         mem_addr       = req_addr[int'(owner)*ADDR_W +: ADDR_W];
         mem_write_data = req_wdata[int'(owner)*DATA_W +: DATA_W];
      end
   end

   ap_grant_oh:  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
   ap_rvalid_oh: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rvalid));
   ap_we_grant:  assert property (@(posedge clk) disable iff (!reset_n) mem_we |-> (grant != '0));

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Scoreboard bench for sha_mem_arbiter: random bursts from 4 requesters,
// behavioural grant model, read-return queue, and a final memory compare.
module tb_sha_mem_arbiter;

   localparam int N    = 4;
   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int MEMW = 64;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req = '0, req_we = '0;
   logic [N-1:0]    grant, rvalid;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [DW-1:0]   rdata, mem_write_data, mem_read_data;
   logic            mem_clk, mem_we;
   logic [AW-1:0]   mem_addr;

   always #5 clk = ~clk;

   sha_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .grant(grant), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .rvalid(rvalid),
      .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   // memory model: write at the edge, registered read (1-cycle latency)
   logic [DW-1:0] mem     [MEMW];
   logic [DW-1:0] ref_mem [MEMW];
   always @(posedge mem_clk) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_write_data;
      mem_read_data <= mem[mem_addr[5:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int tag; logic [DW-1:0] data; int due; } exp_t;
   exp_t exp_q[$];

   int n_checks = 0, n_errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   // scoreboard monitor: every rvalid pulse must match the oldest issued read
   always @(negedge clk) begin
      if (reset_n) begin
         if (rvalid != '0) begin
            if (exp_q.size() == 0) begin
               check("rvalid_unexpected", rvalid, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rvalid_tag", rvalid, N'(1) << e.tag);
               check("rdata", rdata, e.data);
               check("rvalid_latency", cyc, e.due);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rvalid_missing", 0, N'(1) << e.tag);
         end
      end
   end

   // requester behaviour and grant reference model
   int rem [N];
   int idle[N];
   int mode;          // 0: 3-cycle bursts back to back, 1: random, 2: wind down
   int m_owner = -1;
   int m_ptr   = 0;
   logic [N-1:0] pred;
   bit pred_vld = 0;

   task automatic garbage(int i);
      req_we[i]              = 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW]   = AW'($urandom_range(0, MEMW-1));
      req_wdata[i*DW +: DW]  = $urandom;
   endtask

   // next owner: keep while requesting, else first requester after the owner (or from the pointer)
   task automatic predict();
      bool_hold: begin
         int excl, start;
         if (m_owner >= 0) begin
            if (req[m_owner]) begin
               pred = N'(1) << m_owner;
               pred_vld = 1;
               disable bool_hold;
            end
         end
         excl = m_owner;
         if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
         start = m_ptr;
         m_owner = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (m_owner < 0 && req[j] && j != excl) m_owner = j;
         end
         pred = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
         pred_vld = 1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (pred_vld) check("grant", grant, pred);
      if (grant == '0) check("idle_mux", {mem_we, mem_addr, mem_write_data}, 0);
      for (int i = 0; i < N; i++) begin
         if (grant[i] && rem[i] > 0) begin
            int a;
            logic [DW-1:0] d;
            a = $urandom_range(0, MEMW-1);
            d = $urandom;
            req_we[i]             = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]  = AW'(a);
            req_wdata[i*DW +: DW] = d;
            if (req_we[i]) ref_mem[a] = d;
            else exp_q.push_back('{i, ref_mem[a], cyc + 1});
            rem[i]--;
            if (rem[i] == 0) begin
               req[i]  = 1'b0;
               idle[i] = (mode == 0) ? 0 : $urandom_range(0, 4);
            end
         end else begin
            garbage(i);
            if (!req[i] && mode != 2) begin
               if (idle[i] > 0) idle[i]--;
               else begin
                  req[i] = 1'b1;
                  rem[i] = (mode == 0) ? 3 : $urandom_range(1, 4);
               end
            end
         end
      end
      predict();
   endtask

   initial begin
      int guard;
      for (int i = 0; i < MEMW; i++) begin
         mem[i]     = DW'(32'hA0 + i);
         ref_mem[i] = DW'(32'hA0 + i);
      end
      mode = 0;
      for (int i = 0; i < N; i++) begin
         rem[i] = 3; idle[i] = 0; garbage(i);
      end
      req = '1;
      repeat (3) @(negedge clk);
      check("reset_grant", grant, 0);
      check("reset_rvalid", rvalid, 0);
      check("reset_mem_we", mem_we, 0);
      check("reset_mem_addr", mem_addr, 0);
      reset_n = 1'b1;
      predict();
      step();
      check("first_grant", grant, 4'b0001);

      repeat (40) step();
      mode = 1;
      repeat (400) step();

      // reset while a read is outstanding under an active grant
      guard = 0;
      do begin
         step();
         guard++;
      end while (!(rvalid != '0 && grant != '0) && guard < 300);
      if (guard >= 300) check("midreset_setup_timeout", guard, 0);
      reset_n = 1'b0;
      #1;
      check("midreset_grant", grant, 0);
      check("midreset_rvalid", rvalid, 0);
      exp_q.delete();
      m_owner = -1; m_ptr = 0; pred_vld = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      predict();
      repeat (300) step();

      mode = 2;
      repeat (40) step();
      check("final_grant_idle", grant, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      for (int i = 0; i < MEMW; i++) check("mem_contents", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
